// File: rtl/vdec1_crc_chk.sv
// vdec1_crc_chk: streaming CRC check engine.
// Takes a block of cfg_len bits, DW bits per beat with the MSB first. The
// block is data followed by its CRC. The engine divides it by the selected
// CRC8/12/16/24 polynomial and reports pass/fail plus the final remainder
// once per block.
module vdec1_crc_chk #(
    parameter int DW    = 1,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [1:0]       cfg_crc_sel,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             din_vld,
    input  logic [DW-1:0]    din,
    output logic             din_rdy,
    output logic             busy,
    output logic             crc_done,
    output logic             crc_ok,
    output logic [23:0]      crc_rem
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       sel_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [23:0]      rem;
    logic [23:0]      rem_nxt;
    logic [LEN_W-1:0] take;
    logic [LEN_W-1:0] cnt_nxt;
    logic [4:0]       crc_bits;
    logic             res_ok;
    logic             done_ok;
    logic             hold_ok;
    logic [23:0]      hold_rem;

    // One division step: shift left, bring the new bit in at bit 0, and fold
    // in the polynomial taps when the outgoing MSB was set.
    function automatic logic [23:0] crc_step(input logic [23:0] r,
                                             input logic        b,
                                             input logic [1:0]  sel);
        logic [23:0] poly;
        logic [23:0] mask;
        logic        msb;
        case (sel)
            2'd0: begin poly = 24'h00009B; mask = 24'h0000FF; msb = r[7];  end
            2'd1: begin poly = 24'h00080F; mask = 24'h000FFF; msb = r[11]; end
            2'd2: begin poly = 24'h001021; mask = 24'h00FFFF; msb = r[15]; end
            default: begin poly = 24'h800063; mask = 24'hFFFFFF; msb = r[23]; end
        endcase
        crc_step = (((r << 1) | {23'd0, b}) & mask) ^ (msb ? poly : '0);
    endfunction

    // Unrolled per-bit division over one beat; bits past the block end are skipped.
    always_comb begin
        rem_nxt = rem;
        for (int unsigned i = 0; i < DW; i++) begin
            if (LEN_W'(i) < cnt) begin
                rem_nxt = crc_step(rem_nxt, din[DW-1-i], sel_q);
            end
        end
    end

    // Bits consumed this beat, remaining count afterwards, and the pass test.
    always_comb begin
        take    = (cnt < LEN_W'(DW)) ? cnt : LEN_W'(DW);
        cnt_nxt = cnt - take;
        case (sel_q)
            2'd0:    crc_bits = 5'd8;
            2'd1:    crc_bits = 5'd12;
            2'd2:    crc_bits = 5'd16;
            default: crc_bits = 5'd24;
        endcase
        // A block no longer than its own CRC can never pass.
        res_ok = (rem == '0) && ({5'd0, len_q} > {{LEN_W{1'b0}}, crc_bits});
    end

    // Control FSM, remainder register and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sel_q    <= '0;
            len_q    <= '0;
            cnt      <= '0;
            rem      <= '0;
            hold_ok  <= 1'b0;
            hold_rem <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_start && !cfg_abort) begin
                        sel_q <= cfg_crc_sel;
                        len_q <= cfg_len;
                        cnt   <= cfg_len;
                        rem   <= '0;
                        state <= (cfg_len != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (cfg_abort) begin
                        state <= ST_IDLE;
                    end else if (din_vld) begin
                        rem <= rem_nxt;
                        cnt <= cnt_nxt;
                        if (cnt_nxt == '0) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (!cfg_abort) begin
                        hold_ok  <= res_ok;
                        hold_rem <= rem;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result is shown live during the DONE cycle so it lines up with crc_done,
    // and from the held copy afterwards; an aborted DONE keeps the old result.
    always_comb begin
        done_ok  = (state == ST_DONE) && !cfg_abort;
        din_rdy  = (state == ST_RUN);
        busy     = (state != ST_IDLE);
        crc_done = done_ok;
        crc_ok   = done_ok ? res_ok : hold_ok;
        crc_rem  = done_ok ? rem : hold_rem;
    end

endmodule
